// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//
// Clocked stimulus/capture stage for a 4-input combinational function block.
// On an accepted start it drives {a,b,c,d} through vectors 0..15 in ascending
// order. Each vector is held for DWELL cycles. The block's f output is sampled
// on the last cycle of each dwell window and stored into bit i of a 16-bit
// truth-table word. A one-cycle done pulse ends the sweep.
//
// Optional feature macro: SWEEP_COMPARE_EN
//   When defined, each sample is compared against EXPECTED[idx]. Mismatches are
//   counted in o_err_cnt, and o_pass reports a clean sweep.
//
// Parameters:
//   DWELL    - cycles each vector is held (1..255)
//   EXPECTED - reference truth table (used only with SWEEP_COMPARE_EN)
//
// Ports:
//   i_clk      - clock, rising edge
//   i_rst_n    - synchronous active-low reset
//   i_start    - begin a sweep (sampled only while idle)
//   i_f        - output of the downstream function block
//   o_a..o_d   - vector bits 3..0 (0 when not sweeping)
//   o_busy     - sweep in progress
//   o_done     - one-cycle pulse after the sweep ends
//   o_tt       - captured truth table, held until the next accepted start
//   o_err_cnt  - mismatch count vs EXPECTED (SWEEP_COMPARE_EN only)
//   o_pass     - 1 when the last sweep had no mismatches (SWEEP_COMPARE_EN only)

module truth_table_sweeper #(
  parameter int unsigned DWELL    = 4,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_f,
  output logic        o_a,
  output logic        o_b,
  output logic        o_c,
  output logic        o_d,
  output logic        o_busy,
  output logic        o_done,
`ifdef SWEEP_COMPARE_EN
  output logic [15:0] o_tt,
  output logic [4:0]  o_err_cnt,
  output logic        o_pass
`else
  output logic [15:0] o_tt
`endif
);

  localparam logic [7:0] DwellLast = 8'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  state_e      r_state;
  logic [3:0]  r_idx;
  logic [7:0]  r_dcnt;
  logic [3:0]  r_vec;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_tt;

  // Last cycle of the current dwell window: f is captured here.
  logic w_sample;
  logic w_last_vec;
  assign w_sample   = (r_state == StDrive) && (r_dcnt == DwellLast);
  assign w_last_vec = (r_idx == 4'hF);

`ifdef SWEEP_COMPARE_EN
  logic [4:0] r_err_cnt;
  logic       r_pass;
  logic       w_mismatch;
  assign w_mismatch = (i_f != EXPECTED[r_idx]);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_idx     <= 4'd0;
      r_dcnt    <= 8'd0;
      r_vec     <= 4'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tt      <= 16'h0000;
`ifdef SWEEP_COMPARE_EN
      r_err_cnt <= 5'd0;
      r_pass    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state   <= StDrive;
            r_idx     <= 4'd0;
            r_dcnt    <= 8'd0;
            r_vec     <= 4'd0;
            r_busy    <= 1'b1;
            r_tt      <= 16'h0000;
`ifdef SWEEP_COMPARE_EN
            r_err_cnt <= 5'd0;
            r_pass    <= 1'b0;
`endif
          end
        end
        StDrive: begin
          if (w_sample) begin
            r_tt[r_idx] <= i_f;
`ifdef SWEEP_COMPARE_EN
            if (w_mismatch) r_err_cnt <= r_err_cnt + 5'd1;
`endif
            if (w_last_vec) begin
              // idx never wraps: the sweep terminates on the final vector.
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_vec   <= 4'd0;
`ifdef SWEEP_COMPARE_EN
              // Include the final sample, whose count update lands this edge.
              r_pass  <= (r_err_cnt == 5'd0) && !w_mismatch;
`endif
            end else begin
              r_idx  <= r_idx + 4'd1;
              r_vec  <= r_idx + 4'd1;
              r_dcnt <= 8'd0;
            end
          end else begin
            r_dcnt <= r_dcnt + 8'd1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_a    = r_vec[3];
  assign o_b    = r_vec[2];
  assign o_c    = r_vec[1];
  assign o_d    = r_vec[0];
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_tt   = r_tt;
`ifdef SWEEP_COMPARE_EN
  assign o_err_cnt = r_err_cnt;
  assign o_pass    = r_pass;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper. Three instances with DWELL of
// 4, 1 and 3 share clock and reset, each driven by its own function model.

module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;

  logic start4, start1, start3;
  logic inv4;
  logic a4, b4, c4, d4, busy4, done4;
  logic a1, b1, c1, d1, busy1, done1;
  logic a3, b3, c3, d3, busy3, done3;
  logic [15:0] tt4, tt1, tt3;
  logic f4, f1, f3;
  logic [3:0] vec4, vec1, vec3;

  int n_checks;
  int n_pass;

  assign vec4 = {a4, b4, c4, d4};
  assign vec1 = {a1, b1, c1, d1};
  assign vec3 = {a3, b3, c3, d3};

  // Function block models: parity (optionally inverted), AND4, constant 1.
  assign f4 = inv4 ? ~(a4 ^ b4 ^ c4 ^ d4) : (a4 ^ b4 ^ c4 ^ d4);
  assign f1 = a1 & b1 & c1 & d1;
  assign f3 = 1'b1;

`ifdef SWEEP_COMPARE_EN
  logic [4:0] err4, err1, err3;
  logic       pass4, pass1, pass3;
`endif

  truth_table_sweeper #(.DWELL(4), .EXPECTED(16'h6996)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_f(f4),
    .o_a(a4), .o_b(b4), .o_c(c4), .o_d(d4), .o_busy(busy4), .o_done(done4),
`ifdef SWEEP_COMPARE_EN
    .o_tt(tt4), .o_err_cnt(err4), .o_pass(pass4)
`else
    .o_tt(tt4)
`endif
  );

  truth_table_sweeper #(.DWELL(1), .EXPECTED(16'h8000)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_f(f1),
    .o_a(a1), .o_b(b1), .o_c(c1), .o_d(d1), .o_busy(busy1), .o_done(done1),
`ifdef SWEEP_COMPARE_EN
    .o_tt(tt1), .o_err_cnt(err1), .o_pass(pass1)
`else
    .o_tt(tt1)
`endif
  );

  truth_table_sweeper #(.DWELL(3), .EXPECTED(16'hFFFF)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_f(f3),
    .o_a(a3), .o_b(b3), .o_c(c3), .o_d(d3), .o_busy(busy3), .o_done(done3),
`ifdef SWEEP_COMPARE_EN
    .o_tt(tt3), .o_err_cnt(err3), .o_pass(pass3)
`else
    .o_tt(tt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    logic [23:0] got;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = {vec4, busy4, done4, vec1, busy1, done1, vec3, busy3, done3, 6'd0};
    if (got !== 24'h0) $display("FAIL reset_ctrl: got %h want 000000", got);
    else n_pass++;
    n_checks++;
    if ({tt4, tt1, tt3} !== 48'h0) $display("FAIL reset_tt: got %h want 0", {tt4, tt1, tt3});
    else n_pass++;
    n_checks++;
`ifdef SWEEP_COMPARE_EN
    if ({err4, pass4} !== 6'h0) $display("FAIL reset_cmp: got %h want 0", {err4, pass4});
    else n_pass++;
    n_checks++;
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_parity_dwell4;
    int  busy_n;
    bit  seen;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    if ({busy4, vec4} !== 5'b1_0000) $display("FAIL p4_first: got %b want 10000", {busy4, vec4});
    else n_pass++;
    n_checks++;
    busy_n = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done4) begin seen = 1'b1; break; end
      if (busy4) busy_n++;
      @(negedge clk);
    end
    if (!seen) $display("FAIL p4_done_timeout: got no done want done");
    else n_pass++;
    n_checks++;
    if (busy_n !== 64) $display("FAIL p4_busy_len: got %0d want 64", busy_n);
    else n_pass++;
    n_checks++;
    if ({busy4, vec4} !== 5'b0) $display("FAIL p4_done_idle: got %b want 00000", {busy4, vec4});
    else n_pass++;
    n_checks++;
    if (tt4 !== 16'h6996) $display("FAIL p4_tt: got %h want 6996", tt4);
    else n_pass++;
    n_checks++;
`ifdef SWEEP_COMPARE_EN
    if ({err4, pass4} !== {5'd0, 1'b1}) $display("FAIL p4_cmp: got err=%0d pass=%b want 0/1",
                                                  err4, pass4);
    else n_pass++;
    n_checks++;
`endif
    @(negedge clk);
    if (done4 !== 1'b0) $display("FAIL p4_done_pulse: got %b want 0", done4);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_and_dwell1_back_to_back;
    int busy_n;
    bit seen;
    for (int run = 0; run < 2; run++) begin
      if (run == 0) begin
        @(negedge clk);
      end else begin
        // Cycle after done: result held, then restart immediately.
        @(negedge clk);
        if (tt1 !== 16'h8000) $display("FAIL d1_hold: got %h want 8000", tt1);
        else n_pass++;
        n_checks++;
      end
      start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      if ({busy1, tt1} !== {1'b1, 16'h0}) $display("FAIL d1_accept%0d: got %b/%h want 1/0000",
                                                   run, busy1, tt1);
      else n_pass++;
      n_checks++;
      busy_n = 0; seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        if (done1) begin seen = 1'b1; break; end
        if (busy1) busy_n++;
        @(negedge clk);
      end
      if (!seen || busy_n !== 16) $display("FAIL d1_busy_len%0d: got %0d done=%b want 16 done=1",
                                           run, busy_n, seen);
      else n_pass++;
      n_checks++;
      if (tt1 !== 16'h8000) $display("FAIL d1_tt%0d: got %h want 8000", run, tt1);
      else n_pass++;
      n_checks++;
    end
  endtask

  task automatic test_start_ignored;
    int busy_n, done_n;
    bit p3, p9;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    busy_n = 0; done_n = 0; p3 = 1'b0; p9 = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (done4) done_n++;
      if (busy4) busy_n++;
      start4 = 1'b0;
      if (busy4 && vec4 == 4'd3 && !p3) begin start4 = 1'b1; p3 = 1'b1; end
      if (busy4 && vec4 == 4'd9 && !p9) begin start4 = 1'b1; p9 = 1'b1; end
      @(negedge clk);
    end
    start4 = 1'b0;
    if (!(p3 && p9)) $display("FAIL rs_pulses: got %b%b want 11", p3, p9);
    else n_pass++;
    n_checks++;
    if (busy_n !== 64) $display("FAIL rs_busy_len: got %0d want 64", busy_n);
    else n_pass++;
    n_checks++;
    if (done_n !== 1) $display("FAIL rs_done_cnt: got %0d want 1", done_n);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_reset_mid_sweep;
    int  busy_n, done_n;
    bit  seen;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (vec4 == 4'd7) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) $display("FAIL rm_reach7: got no vector 7 want vector 7");
    else n_pass++;
    n_checks++;
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    if ({busy4, done4, vec4, tt4} !== 22'h0) $display("FAIL rm_clear: got %h want 0",
                                                      {busy4, done4, vec4, tt4});
    else n_pass++;
    n_checks++;
    done_n = 0;
    for (int i = 0; i < 80; i++) begin
      if (done4 || busy4) done_n++;
      @(negedge clk);
    end
    if (done_n !== 0) $display("FAIL rm_no_done: got %0d active cycles want 0", done_n);
    else n_pass++;
    n_checks++;
    start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    busy_n = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done4) begin seen = 1'b1; break; end
      if (busy4) busy_n++;
      @(negedge clk);
    end
    if (!seen || busy_n !== 64 || tt4 !== 16'h6996)
      $display("FAIL rm_fresh: got busy=%0d done=%b tt=%h want 64/1/6996", busy_n, seen, tt4);
    else n_pass++;
    n_checks++;
    @(negedge clk);
  endtask

`ifdef SWEEP_COMPARE_EN
  task automatic test_compare_inverted;
    bit seen;
    inv4 = 1'b1;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done4) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen || tt4 !== 16'h9669) $display("FAIL cmp_inv_tt: got %h done=%b want 9669/1",
                                            tt4, seen);
    else n_pass++;
    n_checks++;
    if ({err4, pass4} !== {5'd16, 1'b0}) $display("FAIL cmp_inv: got err=%0d pass=%b want 16/0",
                                                  err4, pass4);
    else n_pass++;
    n_checks++;
    inv4 = 1'b0;
    @(negedge clk);
  endtask
`endif

  task automatic test_ones_dwell3;
    int cyc;
    int exp_v;
    bit seen;
    logic [3:0] exp_vec;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    cyc = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done3) begin seen = 1'b1; break; end
      if (busy3) begin
        exp_v   = cyc / 3;
        exp_vec = exp_v[3:0];
        if (vec3 !== exp_vec) $display("FAIL d3_vec: cycle %0d got %h want %h",
                                       cyc, vec3, exp_vec);
        else n_pass++;
        n_checks++;
        cyc++;
      end
      @(negedge clk);
    end
    if (!seen || cyc !== 48) $display("FAIL d3_busy_len: got %0d done=%b want 48/1", cyc, seen);
    else n_pass++;
    n_checks++;
    if ({tt3, vec3} !== {16'hFFFF, 4'h0}) $display("FAIL d3_tt: got %h/%h want ffff/0",
                                                   tt3, vec3);
    else n_pass++;
    n_checks++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    start4   = 1'b0;
    start1   = 1'b0;
    start3   = 1'b0;
    inv4     = 1'b0;
    test_reset();
    test_parity_dwell4();
    test_and_dwell1_back_to_back();
    test_start_ignored();
    test_reset_mid_sweep();
`ifdef SWEEP_COMPARE_EN
    test_compare_inverted();
`endif
    test_ones_dwell3();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
